// File: rtl/multi_edge_detector.sv
// ---------------------------------------------------------------------------
// multi_edge_detector
//
// Purpose:
//   Multi-channel debounced edge detector. Each channel runs its own Moore
//   FSM with a glitch filter. A new input level is accepted only after it has
//   been sampled on STABLE consecutive rising clock edges. When a level is
//   accepted, the channel can emit a one-cycle pulse on the rising edge, the
//   falling edge, or both, depending on the shared mode input.
//
// Parameters:
//   CH      number of independent channels (>= 1)
//   STABLE  consecutive samples a new level must hold before it is accepted
//           (>= 1; 1 means no filtering)
//   CNT_W   width of each per-channel event counter
//
// Ports:
//   clk    in   1         system clock, all state changes on the rising edge
//   RESET  in   1         asynchronous, active-high reset
//   din    in   CH        channel inputs, already synchronised upstream
//   mode   in   2         00 rise, 01 fall, 10 both, 11 pulses disabled
//   clear  in   1         synchronous clear of the event counters
//   pe     out  CH        one-cycle edge pulse per channel
//   level  out  CH        filtered (debounced) level per channel
//   cnt_q  out  CH*CNT_W  packed event counters, channel i at [i*CNT_W +: CNT_W]
//
// Configuration:
//   EDGE_COUNT_EN  when defined, each channel keeps a saturating count of its
//                  pe pulses. When undefined, cnt_q is tied to 0 and clear is
//                  ignored; the port list is the same in both builds.
// ---------------------------------------------------------------------------
module multi_edge_detector #(
  parameter int CH     = 4,
  parameter int STABLE = 3,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic [CH-1:0]       din,
  input  logic [1:0]          mode,
  input  logic                clear,
  output logic [CH-1:0]       pe,
  output logic [CH-1:0]       level,
  output logic [CH*CNT_W-1:0] cnt_q
);

  // Width of the per-channel pending counter; it must be able to hold
  // values up to STABLE-1.
  localparam int PW = $clog2(STABLE + 1);

  localparam logic [PW-1:0] PEND_LAST = PW'(STABLE - 1);
  localparam logic [PW-1:0] PEND_ONE  = PW'(1);

  typedef enum logic [2:0] {
    LOW       = 3'd0,
    RISE_PEND = 3'd1,
    EDGE_R    = 3'd2,
    HIGH      = 3'd3,
    FALL_PEND = 3'd4,
    EDGE_F    = 3'd5
  } state_t;

  state_t          state_q [CH];
  state_t          state_d [CH];
  logic [PW-1:0]   pend_q  [CH];
  logic [PW-1:0]   pend_d  [CH];

  logic            rise_en;
  logic            fall_en;

  // State and pending-count registers for every channel. Reset drops all
  // channels straight to LOW, even in the middle of a pending window.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= LOW;
        pend_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
      end
    end
  end

  // Next-state logic. The EDGE_* states last exactly one cycle and leave
  // exactly as the steady state they lead into, so a change of level right
  // after an edge already starts the opposite pending window. With STABLE==1
  // the pending states are skipped and each new sample is reported at once.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];

      case (state_q[i])
        LOW, EDGE_F: begin
          pend_d[i] = '0;
          if (din[i]) begin
            if (STABLE == 1) begin
              state_d[i] = EDGE_R;
            end else begin
              state_d[i] = RISE_PEND;
              pend_d[i]  = PEND_ONE;
            end
          end else begin
            state_d[i] = LOW;
          end
        end

        RISE_PEND: begin
          if (!din[i]) begin
            state_d[i] = LOW;
            pend_d[i]  = '0;
          end else if (pend_q[i] == PEND_LAST) begin
            state_d[i] = EDGE_R;
            pend_d[i]  = '0;
          end else begin
            pend_d[i]  = pend_q[i] + PEND_ONE;
          end
        end

        HIGH, EDGE_R: begin
          pend_d[i] = '0;
          if (!din[i]) begin
            if (STABLE == 1) begin
              state_d[i] = EDGE_F;
            end else begin
              state_d[i] = FALL_PEND;
              pend_d[i]  = PEND_ONE;
            end
          end else begin
            state_d[i] = HIGH;
          end
        end

        FALL_PEND: begin
          if (din[i]) begin
            state_d[i] = HIGH;
            pend_d[i]  = '0;
          end else if (pend_q[i] == PEND_LAST) begin
            state_d[i] = EDGE_F;
            pend_d[i]  = '0;
          end else begin
            pend_d[i]  = pend_q[i] + PEND_ONE;
          end
        end

        default: begin
          state_d[i] = LOW;
          pend_d[i]  = '0;
        end
      endcase
    end
  end

  // Moore outputs. level follows the accepted level, so it is already high
  // in FALL_PEND and still low in RISE_PEND. pe combines the registered state
  // with the live mode input; mode is expected to change only rarely.
  always_comb begin
    rise_en = (mode == 2'b00) || (mode == 2'b10);
    fall_en = (mode == 2'b01) || (mode == 2'b10);
    for (int i = 0; i < CH; i++) begin
      level[i] = (state_q[i] == EDGE_R) || (state_q[i] == HIGH) ||
                 (state_q[i] == FALL_PEND);
      pe[i]    = ((state_q[i] == EDGE_R) && rise_en) ||
                 ((state_q[i] == EDGE_F) && fall_en);
    end
  end

`ifdef EDGE_COUNT_EN

  logic [CNT_W-1:0] evt_q [CH];

  // Per-channel saturating pulse counters. clear has priority over a pulse
  // in the same cycle, and a counter at all-ones holds instead of wrapping.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CH; i++) begin
        evt_q[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < CH; i++) begin
        evt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (pe[i] && (evt_q[i] != {CNT_W{1'b1}})) begin
          evt_q[i] <= evt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pack the counters onto the flat output bus.
  always_comb begin
    cnt_q = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_q[i*CNT_W +: CNT_W] = evt_q[i];
    end
  end

`else

  // Counting is compiled out: the bus reads zero and clear has no effect.
  logic unused_clear;

  assign unused_clear = clear;
  assign cnt_q        = '0;

`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// ---------------------------------------------------------------------------
// tb_multi_edge_detector
//
// Self-checking bench for multi_edge_detector. Two instances are exercised:
// a 4-channel STABLE=3 instance and a 1-channel STABLE=1 instance that shares
// din[0]. A run-length reference model predicts pe, level and counters each
// cycle; the predictions are queued on the sampling edge and compared on the
// following falling edge. Build with +define+EDGE_COUNT_EN to check counters.
// ---------------------------------------------------------------------------
module tb_multi_edge_detector;

  localparam int CH     = 4;
  localparam int STABLE = 3;
  localparam int CNT_W  = 8;
  localparam int LANES  = CH + 1;

  logic                clk = 1'b0;
  logic                RESET;
  logic [CH-1:0]       din;
  logic [1:0]          mode;
  logic                clear;
  logic [CH-1:0]       pe;
  logic [CH-1:0]       level;
  logic [CH*CNT_W-1:0] cnt_q;
  logic [0:0]          pe1;
  logic [0:0]          level1;
  logic [CNT_W-1:0]    cnt_q1;

  multi_edge_detector #(.CH(CH), .STABLE(STABLE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .RESET (RESET),
    .din   (din),
    .mode  (mode),
    .clear (clear),
    .pe    (pe),
    .level (level),
    .cnt_q (cnt_q)
  );

  multi_edge_detector #(.CH(1), .STABLE(1), .CNT_W(CNT_W)) dut1 (
    .clk   (clk),
    .RESET (RESET),
    .din   (din[0:0]),
    .mode  (mode),
    .clear (clear),
    .pe    (pe1),
    .level (level1),
    .cnt_q (cnt_q1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0]       pe;
    logic [LANES-1:0]       lvl;
    logic [LANES*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic m_lvl [LANES];
  logic m_er  [LANES];
  logic m_ef  [LANES];
  int   m_run [LANES];
  int   m_cnt [LANES];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses      [LANES];
  int first_pe_at [LANES];
  int last_pe_at  [LANES];
  int level_rises [LANES];
  logic [LANES-1:0] prev_level;

  function automatic int stable_of(input int l);
    return (l < CH) ? STABLE : 1;
  endfunction

  function automatic logic model_pe(input int l);
    return (m_er[l] && (mode == 2'b00 || mode == 2'b10)) ||
           (m_ef[l] && (mode == 2'b01 || mode == 2'b10));
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      e.pe[l]  = model_pe(l);
      e.lvl[l] = m_lvl[l];
`ifdef EDGE_COUNT_EN
      e.cnt[l*CNT_W +: CNT_W] = CNT_W'(m_cnt[l]);
`endif
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int l = 0; l < LANES; l++) begin
      m_lvl[l] = 1'b0;
      m_er[l]  = 1'b0;
      m_ef[l]  = 1'b0;
      m_run[l] = 0;
      m_cnt[l] = 0;
    end
  endtask

  // One sampling edge: counters see the pulse of the ending cycle, then the
  // filter consumes the new sample.
  task automatic modelStep(input logic [LANES-1:0] s);
    for (int l = 0; l < LANES; l++) begin
      if (clear) m_cnt[l] = 0;
      else if (model_pe(l) && m_cnt[l] < 255) m_cnt[l]++;
      m_er[l] = 1'b0;
      m_ef[l] = 1'b0;
      if (s[l] != m_lvl[l]) begin
        m_run[l]++;
        if (m_run[l] >= stable_of(l)) begin
          m_lvl[l] = s[l];
          m_run[l] = 0;
          m_er[l]  = s[l];
          m_ef[l]  = !s[l];
        end
      end else begin
        m_run[l] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clearStats();
    for (int l = 0; l < LANES; l++) begin
      pulses[l]      = 0;
      first_pe_at[l] = -1;
      last_pe_at[l]  = -1;
      level_rises[l] = 0;
    end
  endtask

  // Called just after a falling edge: drive inputs, predict on the rising
  // edge, compare on the next falling edge.
  task automatic applyStimulus(input logic [CH-1:0] d, input logic [1:0] m,
                               input logic c, input logic r);
    exp_t e;
    logic [LANES-1:0] obs_pe;
    logic [LANES-1:0] obs_lvl;
    din   = d;
    mode  = m;
    clear = c;
    RESET = r;
    if (r) begin
      #1;
      checkOutput("async_reset", {pe1, pe, level1, level, cnt_q1, cnt_q}, '0);
      modelReset();
      sb.delete();
    end
    @(posedge clk);
    if (r) modelReset();
    else   modelStep({din[0], din});
    sb.push_back(model_outputs());
    @(negedge clk);
    cyc++;
    e       = sb.pop_front();
    obs_pe  = {pe1, pe};
    obs_lvl = {level1, level};
    checkOutput("pe",    64'(obs_pe),  64'(e.pe));
    checkOutput("level", 64'(obs_lvl), 64'(e.lvl));
    checkOutput("cnt",   64'({cnt_q1, cnt_q}), 64'(e.cnt));
    for (int l = 0; l < LANES; l++) begin
      if (obs_pe[l]) begin
        pulses[l]++;
        if (first_pe_at[l] < 0) first_pe_at[l] = cyc;
        last_pe_at[l] = cyc;
      end
      if (obs_lvl[l] && !prev_level[l]) level_rises[l]++;
    end
    prev_level = obs_lvl;
  endtask

  task automatic holdInputs(input logic [CH-1:0] d, input logic [1:0] m, input int n);
    for (int k = 0; k < n; k++) applyStimulus(d, m, 1'b0, 1'b0);
  endtask

  logic [63:0] sat_exp;
  int          release_at;
  logic [CH-1:0] rnd_din;
  logic [1:0]    rnd_mode;

  initial begin
    RESET      = 1'b1;
    din        = '0;
    mode       = 2'b00;
    clear      = 1'b0;
    prev_level = '0;
    modelReset();
    clearStats();
    #3;
    checkOutput("reset_state", {pe1, pe, level1, level, cnt_q1, cnt_q}, '0);
    @(negedge clk);
    applyStimulus('0, 2'b00, 1'b0, 1'b1);
    applyStimulus('0, 2'b00, 1'b0, 1'b1);
    holdInputs('0, 2'b00, 2);

    // Single rising edge on channel 0.
    clearStats();
    holdInputs(4'b0001, 2'b00, 6);
    checkOutput("t1_pulses0", 64'(pulses[0]), 64'd1);
    checkOutput("t1_when0",   64'(first_pe_at[0] - (cyc - 6)), 64'd3);
    checkOutput("t1_others",  64'(pulses[1] + pulses[2] + pulses[3]), 64'd0);
    holdInputs('0, 2'b00, 5);

    // Glitch rejection on channel 1.
    clearStats();
    holdInputs(4'b0010, 2'b00, 2);
    holdInputs('0, 2'b00, 5);
    checkOutput("t2_glitch_pulses", 64'(pulses[1]), 64'd0);
    checkOutput("t2_glitch_level",  64'(level_rises[1]), 64'd0);
    holdInputs(4'b0010, 2'b00, 3);
    holdInputs('0, 2'b00, 5);
    checkOutput("t2_accept_pulses", 64'(pulses[1]), 64'd1);

    // Mode selection on channel 2.
    clearStats();
    holdInputs(4'b0100, 2'b10, 10);
    holdInputs('0, 2'b10, 6);
    checkOutput("t3_both_pulses",  64'(pulses[2]), 64'd2);
    checkOutput("t3_both_spacing", 64'(last_pe_at[2] - first_pe_at[2]), 64'd10);
    clearStats();
    holdInputs(4'b0100, 2'b01, 10);
    holdInputs('0, 2'b01, 6);
    checkOutput("t3_fall_pulses",  64'(pulses[2]), 64'd1);
    checkOutput("t3_fall_when",    64'(first_pe_at[2] - (cyc - 6)), 64'd3);
    clearStats();
    holdInputs(4'b0100, 2'b11, 10);
    holdInputs('0, 2'b11, 6);
    checkOutput("t3_off_pulses",   64'(pulses[2]), 64'd0);
    checkOutput("t3_off_level",    64'(level_rises[2]), 64'd1);

    // Reset while channel 3 is two samples into a rise.
    clearStats();
    holdInputs(4'b1000, 2'b00, 2);
    applyStimulus(4'b1000, 2'b00, 1'b0, 1'b1);
    applyStimulus(4'b1000, 2'b00, 1'b0, 1'b1);
    release_at = cyc;
    holdInputs(4'b1000, 2'b00, 6);
    checkOutput("t4_pulses3", 64'(pulses[3]), 64'd1);
    checkOutput("t4_delay3",  64'(first_pe_at[3] - release_at), 64'(STABLE));
    holdInputs('0, 2'b00, 5);

    // Unfiltered instance with din[0] toggling every clock.
    clearStats();
    for (int k = 0; k < 8; k++) holdInputs((k % 2 == 0) ? 4'b0001 : 4'b0000, 2'b10, 1);
    checkOutput("t5_toggle_pulses", 64'(pulses[LANES-1]), 64'd8);
    holdInputs('0, 2'b00, 5);

    // Counter saturation, then clear colliding with a pulse.
    for (int k = 0; k < 300; k++) begin
      holdInputs(4'b0001, 2'b00, 4);
      holdInputs('0, 2'b00, 4);
    end
`ifdef EDGE_COUNT_EN
    sat_exp = 64'd255;
`else
    sat_exp = 64'd0;
`endif
    checkOutput("t6_saturated", 64'(cnt_q[CNT_W-1:0]), sat_exp);
    holdInputs(4'b0001, 2'b00, 3);
    checkOutput("t6_pe_before_clear", 64'(pe[0]), 64'd1);
    applyStimulus(4'b0001, 2'b00, 1'b1, 1'b0);
    checkOutput("t6_cleared", 64'(cnt_q[CNT_W-1:0]), 64'd0);
    holdInputs('0, 2'b00, 5);

    // Random traffic with occasional mode changes and clears.
    rnd_din  = '0;
    rnd_mode = 2'b10;
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < CH; b++)
        if ($urandom_range(0, 3) == 0) rnd_din[b] = ~rnd_din[b];
      if (k % 40 == 0) rnd_mode = 2'($urandom_range(0, 3));
      applyStimulus(rnd_din, rnd_mode, ($urandom_range(0, 15) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
